// File: rtl/router_pkt_source.sv
// Source-side packet transmitter for the router: buffers payload bytes, then emits
// header, payload and parity back-to-back so pkt_valid never gaps mid-packet.
module router_pkt_source #(
    parameter int DEPTH           = 64,
    parameter bit PARITY_INCL_HDR = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_addr,
    input  logic [5:0] cmd_len,
    input  logic       cmd_corrupt,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic [7:0] pl_data,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       pkt_done,
    output logic       cmd_err,
    output logic       tx_active
);
    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, WAIT_DATA, HEADER, PAYLOAD, PARITY} state_t;
    state_t state, state_nx;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    addr_q;
    logic [5:0]    len_q, remaining;
    logic          corrupt_q;
    logic [7:0]    parity, parity_nx, hdr;
    logic          cmd_hs, cmd_bad, push, pop, accept, hdr_go;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:      if (cmd_hs && !cmd_bad)           state_nx = WAIT_DATA;
            WAIT_DATA: if (hdr_go)                       state_nx = HEADER;
            HEADER:    if (accept)                       state_nx = PAYLOAD;
            PAYLOAD:   if (accept && remaining == 6'd1)  state_nx = PARITY;
            PARITY:    if (accept)                       state_nx = IDLE;
            default:                                     state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE) && !reset;
        cmd_hs    = cmd_valid && cmd_ready;
        cmd_bad   = (cmd_len == 6'd0) || (cmd_addr == 2'd3);
        accept    = (state == HEADER || state == PAYLOAD || state == PARITY) && !busy;
        pop       = (state == PAYLOAD) && !busy;
        hdr_go    = (state == WAIT_DATA) && (count >= (AW+1)'(len_q));
        pl_ready  = (count != FULL);
        push      = pl_valid && pl_ready;
        hdr       = {len_q, addr_q};
        parity_nx = parity ^ data_out;
    end

    // Storage is not reset; clearing the pointers is what discards stale payload.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= pl_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            data_out  <= 8'h00;
            pkt_valid <= 1'b0;
            pkt_done  <= 1'b0;
            cmd_err   <= 1'b0;
            tx_active <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            corrupt_q <= 1'b0;
            remaining <= '0;
            parity    <= 8'h00;
        end else begin
            pkt_done <= 1'b0;
            cmd_err  <= 1'b0;
            case (state)
                IDLE: if (cmd_hs) begin
                    addr_q    <= cmd_addr;
                    len_q     <= cmd_len;
                    corrupt_q <= cmd_corrupt;
                    cmd_err   <= cmd_bad;
                end
                WAIT_DATA: if (hdr_go) begin
                    data_out  <= hdr;
                    pkt_valid <= 1'b1;
                    tx_active <= 1'b1;
                    parity    <= PARITY_INCL_HDR ? hdr : 8'h00;
                end
                HEADER: if (accept) begin
                    data_out  <= mem[rd_ptr];
                    remaining <= len_q;
                end
                // The byte on data_out is the buffer head; the next one sits at rd_ptr+1.
                PAYLOAD: if (accept) begin
                    remaining <= remaining - 6'd1;
                    parity    <= parity_nx;
                    if (remaining == 6'd1) begin
                        data_out  <= parity_nx ^ {7'b0, corrupt_q};
                        pkt_valid <= 1'b0;
                    end else begin
                        data_out  <= mem[rd_ptr + AW'(1)];
                    end
                end
                PARITY: if (accept) begin
                    data_out  <= 8'h00;
                    tx_active <= 1'b0;
                    pkt_done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
